// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   state_e      : command-slot state (IDLE / ISSUE)
//   owner_e      : which requester owns the issued command
//   IO_SPACE_TOP : top two address bits that select I/O space
//   DEF_STARVE_LIMIT : default bound on consecutive contended CPU wins
package mem_arb_pkg;
  typedef enum logic {IDLE, ISSUE} state_e;
  typedef enum logic {OWN_CPU, OWN_DEV} owner_e;
  localparam logic [1:0] IO_SPACE_TOP     = 2'b11;
  localparam int         DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/mem_arb_picker.sv
// Winner select with bounded device starvation.
//   clk, rst            : clock, async active-low reset
//   cpu_req, dev_req    : live requests for this cycle
//   cpu_win, dev_win    : combinational winner (at most one high)
// CPU wins contention until it has won STARVE_LIMIT contended cycles in a
// row; the device then gets exactly one forced win.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dev_req,
  output logic cpu_win,
  output logic dev_win
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] streak;

  always_comb begin
    cpu_win = cpu_req && !(dev_req && (streak == LIM));
    dev_win = dev_req && !cpu_win;
  end

  // A CPU win with the device waiting can only happen below LIM, so the
  // counter saturates naturally; the extra guard keeps it safe regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        streak <= '0;
    else if (!dev_req || dev_win)    streak <= '0;
    else if (cpu_win && streak != LIM) streak <= streak + 4'd1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory.
//   clk, rst                     : clock, async active-low reset
//   cpu_* / dev_*                : req/we/adr/wdata in, gnt/rvalid/rdata out
//   mem_re, mem_we, mem_adr,
//   mem_wdata, mem_rdata         : memory command port (rdata valid before
//                                  the rising edge ending the issue cycle)
//   io_sel, io_we, io_adr,
//   io_wdata, io_rdata           : I/O window port
// Build option MEM_ARB_IO_DECODE_EN: commands whose top address bits equal
// IO_SPACE_TOP go to io_* instead of mem_*. Without it, io_* are tied 0.
// A request sampled at edge N issues (gnt + strobe) in cycle N+1; read data
// is captured at the end of that cycle and returned with rvalid in N+2.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_adr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_gnt,
  output logic              dev_rvalid,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              io_sel,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_adr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);
  typedef struct packed {
    owner_e            owner;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  logic   cpu_win, dev_win;
  logic   is_io, issue, rd_done;
  logic [DATA_W-1:0] rd_src;

  mem_arb_picker #(.STARVE_LIMIT(STARVE_LIMIT)) u_picker (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .dev_req (dev_req),
    .cpu_win (cpu_win),
    .dev_win (dev_win)
  );

  // Next state / command select. A new winner can be loaded on the same edge
  // that retires the current command, giving one access per cycle.
  always_comb begin
    state_d = IDLE;
    cmd_d   = cmd_q;
    if (cpu_win) begin
      state_d = ISSUE;
      cmd_d   = '{owner: OWN_CPU, we: cpu_we, adr: cpu_adr, wdata: cpu_wdata};
    end else if (dev_win) begin
      state_d = ISSUE;
      cmd_d   = '{owner: OWN_DEV, we: dev_we, adr: dev_adr, wdata: dev_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  assign issue   = (state_q == ISSUE);
  assign rd_done = issue && !cmd_q.we;
  assign cpu_gnt = issue && (cmd_q.owner == OWN_CPU);
  assign dev_gnt = issue && (cmd_q.owner == OWN_DEV);

`ifdef MEM_ARB_IO_DECODE_EN
  assign is_io     = (cmd_q.adr[ADDR_W-1 -: 2] == IO_SPACE_TOP);
  assign rd_src    = is_io ? io_rdata : mem_rdata;
  assign io_sel    = issue && is_io;
  assign io_we     = issue && is_io && cmd_q.we;
  assign io_adr    = is_io ? cmd_q.adr   : '0;
  assign io_wdata  = is_io ? cmd_q.wdata : '0;
  assign mem_adr   = is_io ? '0 : cmd_q.adr;
  assign mem_wdata = is_io ? '0 : cmd_q.wdata;
`else
  logic unused_io;
  assign unused_io = ^io_rdata;
  assign is_io     = 1'b0;
  assign rd_src    = mem_rdata;
  assign io_sel    = 1'b0;
  assign io_we     = 1'b0;
  assign io_adr    = '0;
  assign io_wdata  = '0;
  assign mem_adr   = cmd_q.adr;
  assign mem_wdata = cmd_q.wdata;
`endif

  assign mem_re = issue && !is_io && !cmd_q.we;
  assign mem_we = issue && !is_io &&  cmd_q.we;

  // Read return: capture at the end of the issue cycle, strobe the owner
  // only. rdata registers hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      dev_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dev_rdata  <= '0;
    end else begin
      cpu_rvalid <= rd_done && (cmd_q.owner == OWN_CPU);
      dev_rvalid <= rd_done && (cmd_q.owner == OWN_DEV);
      if (rd_done && cmd_q.owner == OWN_CPU) cpu_rdata <= rd_src;
      if (rd_done && cmd_q.owner == OWN_DEV) dev_rdata <= rd_src;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for single,
// back-to-back and contended accesses, then hand-written sequences for
// starvation bounding, mid-access reset and the I/O window.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dev_req, dev_we;
  logic [15:0] cpu_adr, cpu_wdata, dev_adr, dev_wdata;
  logic        cpu_gnt, cpu_rvalid, dev_gnt, dev_rvalid;
  logic [15:0] cpu_rdata, dev_rdata;
  logic        mem_re, mem_we, io_sel, io_we;
  logic [15:0] mem_adr, mem_wdata, mem_rdata, io_adr, io_wdata;
  logic [15:0] io_rdata = 16'h00AA;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dev_req(dev_req), .dev_we(dev_we), .dev_adr(dev_adr), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
    .io_rdata(io_rdata)
  );

  // Memory contents: one planted word, everything else is adr ^ A5A5.
  function automatic logic [15:0] memval(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  // Memory samples on the falling edge; poison data when not reading.
  always @(negedge clk) mem_rdata <= mem_re ? memval(mem_adr) : 16'hDEAD;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wdata = cd;
    dev_req = dr; dev_we = dw; dev_adr = da; dev_wdata = dd;
  endtask

  typedef struct {
    logic creq, cwe; logic [15:0] cadr, cwd;
    logic dreq, dwe; logic [15:0] dadr, dwd;
    logic cgnt, dgnt, mre, mwe; logic [15:0] madr, mwd;
    logic cval, dval; logic [15:0] crd, drd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    //          cpu in                     dev in                     gnt  strobes  adr      wdata    rvalid  rdata
    vecs[0]  = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0, 1,0, 16'h0010,16'h0000, 0,0, 16'h0000,16'h0000};
    vecs[1]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 0,0, 16'h0000,16'h0000, 1,0, 16'hBEEF,16'h0000};
    vecs[2]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0200,16'h1234, 0,1, 0,1, 16'h0200,16'h1234, 0,0, 16'h0000,16'h0000};
    vecs[3]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 0,0, 16'h0000,16'h0000, 0,0, 16'h0000,16'h0000};
    vecs[4]  = '{1,0,16'h0001,16'h0000, 0,0,16'h0000,16'h0000, 1,0, 1,0, 16'h0001,16'h0000, 0,0, 16'h0000,16'h0000};
    vecs[5]  = '{1,0,16'h0002,16'h0000, 0,0,16'h0000,16'h0000, 1,0, 1,0, 16'h0002,16'h0000, 1,0, 16'hA5A4,16'h0000};
    vecs[6]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 0,0, 16'h0000,16'h0000, 1,0, 16'hA5A7,16'h0000};
    vecs[7]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 0,0, 16'h0000,16'h0000, 0,0, 16'h0000,16'h0000};
    vecs[8]  = '{1,1,16'h0400,16'hAAAA, 1,0,16'h0300,16'h0000, 1,0, 0,1, 16'h0400,16'hAAAA, 0,0, 16'h0000,16'h0000};
    vecs[9]  = '{0,0,16'h0000,16'h0000, 1,0,16'h0300,16'h0000, 0,1, 1,0, 16'h0300,16'h0000, 0,0, 16'h0000,16'h0000};
    vecs[10] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 0,0, 16'h0000,16'h0000, 0,1, 16'h0000,16'hA6A5};

    // Reset state
    rst = 1'b0;
    drive(0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst cpu_gnt", {15'b0, cpu_gnt}, 16'h0);
    chk("rst dev_gnt", {15'b0, dev_gnt}, 16'h0);
    chk("rst rvalid", {14'b0, cpu_rvalid, dev_rvalid}, 16'h0);
    chk("rst strobes", {12'b0, mem_re, mem_we, io_sel, io_we}, 16'h0);
    chk("rst mem_adr", mem_adr, 16'h0);
    chk("rst cpu_rdata", cpu_rdata, 16'h0);
    @(negedge clk) rst = 1'b1;

    // Table-driven per-cycle vectors
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].cadr, vecs[i].cwd,
            vecs[i].dreq, vecs[i].dwe, vecs[i].dadr, vecs[i].dwd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cpu_gnt", i), {15'b0, cpu_gnt}, {15'b0, vecs[i].cgnt});
      chk($sformatf("v%0d dev_gnt", i), {15'b0, dev_gnt}, {15'b0, vecs[i].dgnt});
      chk($sformatf("v%0d mem_re", i), {15'b0, mem_re}, {15'b0, vecs[i].mre});
      chk($sformatf("v%0d mem_we", i), {15'b0, mem_we}, {15'b0, vecs[i].mwe});
      chk($sformatf("v%0d cpu_rvalid", i), {15'b0, cpu_rvalid}, {15'b0, vecs[i].cval});
      chk($sformatf("v%0d dev_rvalid", i), {15'b0, dev_rvalid}, {15'b0, vecs[i].dval});
      if (vecs[i].mre || vecs[i].mwe) chk($sformatf("v%0d mem_adr", i), mem_adr, vecs[i].madr);
      if (vecs[i].mwe)  chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
      if (vecs[i].cval) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].crd);
      if (vecs[i].dval) chk($sformatf("v%0d dev_rdata", i), dev_rdata, vecs[i].drd);
    end

    // Continuous contention: C,C,C,C,D repeating
    drive(1,0,16'h0100,16'h0, 1,0,16'h0300,16'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d dev_gnt", i), {15'b0, dev_gnt}, {15'b0, (i % 5) == 4});
      chk($sformatf("starve%0d cpu_gnt", i), {15'b0, cpu_gnt}, {15'b0, (i % 5) != 4});
    end

    // Streak clears when the device drops its request
    begin
      logic [7:0] dpat;
      logic [7:0] dexp;
      dpat = 8'b1111_1011;  // bit i = dev_req in cycle i
      dexp = 8'b1000_0000;  // bit i = expected dev_gnt
      for (int i = 0; i < 8; i++) begin
        dev_req = dpat[i];
        @(posedge clk);
        #1;
        chk($sformatf("clr%0d dev_gnt", i), {15'b0, dev_gnt}, {15'b0, dexp[i]});
        chk($sformatf("clr%0d cpu_gnt", i), {15'b0, cpu_gnt}, {15'b0, ~dexp[i]});
      end
    end
    drive(0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the issue cycle of a read
    drive(1,0,16'h0010,16'h0, 0,0,16'h0,16'h0);
    @(posedge clk);
    #1;
    chk("rmid issue gnt", {15'b0, cpu_gnt}, 16'h1);
    cpu_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rmid gnt", {14'b0, cpu_gnt, dev_gnt}, 16'h0);
    chk("rmid strobes", {12'b0, mem_re, mem_we, io_sel, io_we}, 16'h0);
    chk("rmid mem_adr", mem_adr, 16'h0);
    chk("rmid cpu_rdata", cpu_rdata, 16'h0);
    @(posedge clk);
    #1;
    chk("rmid rvalid", {14'b0, cpu_rvalid, dev_rvalid}, 16'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid post rvalid", {14'b0, cpu_rvalid, dev_rvalid}, 16'h0);
    chk("rmid post mem_re", {15'b0, mem_re}, 16'h0);

    // Read at the I/O window address
    drive(1,0,16'hC004,16'h0, 0,0,16'h0,16'h0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    chk("io gnt", {15'b0, cpu_gnt}, 16'h1);
`ifdef MEM_ARB_IO_DECODE_EN
    chk("io io_sel", {15'b0, io_sel}, 16'h1);
    chk("io mem_re", {15'b0, mem_re}, 16'h0);
    chk("io io_adr", io_adr, 16'hC004);
`else
    chk("io io_sel", {15'b0, io_sel}, 16'h0);
    chk("io mem_re", {15'b0, mem_re}, 16'h1);
    chk("io mem_adr", mem_adr, 16'hC004);
`endif
    @(posedge clk);
    #1;
    chk("io cpu_rvalid", {15'b0, cpu_rvalid}, 16'h1);
`ifdef MEM_ARB_IO_DECODE_EN
    chk("io cpu_rdata", cpu_rdata, 16'h00AA);
`else
    chk("io cpu_rdata", cpu_rdata, 16'h65A1);
`endif
    @(posedge clk);
    #1;
    chk("io rvalid drop", {15'b0, cpu_rvalid}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
